// File: rtl/mux_41_bv_if.sv
// Bus bundle for the 4-to-1 lane selector: lane inputs, select, capture
// enable, and both the combinational and registered results.
interface mux_41_bv_if #(
  parameter int W = 1
);

  logic [4*W-1:0] i;
  logic [1:0]     sel;
  logic           en;
  logic [W-1:0]   f;
  logic [W-1:0]   f_q;
  logic [1:0]     sel_q;
  logic           vld_q;

  // Driver side: supplies lanes/select/enable and observes the results
  modport master (
    output i, sel, en,
    input  f, f_q, sel_q, vld_q
  );

  // Selector side: consumes lanes/select/enable and produces the results
  modport slave (
    input  i, sel, en,
    output f, f_q, sel_q, vld_q
  );

endinterface

// File: rtl/mux_41_bv.sv
// 4-to-1 lane selector. Lane k of the packed bus sits at i[k*W +: W].
// The combinational output f is the lane picked by sel; an optional
// registered copy (f_q, sel_q, vld_q) captures it when en is high.
module mux_41_bv #(
  parameter int W       = 1,
  parameter bit REG_OUT = 1'b1
) (
  input logic       clk,
  input logic       rst,
  mux_41_bv_if.slave bus
);

  logic [W-1:0] lane [4];
  logic [W-1:0] f_sel;

  // Unpack the flat lane bus into an indexable array, lane 0 at the LSBs
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane[k] = bus.i[k*W +: W];
    end
  end

  // Pick the lane named by sel; an unknown select yields all-X in simulation
  always_comb begin
    f_sel = 'x;
    case (bus.sel)
      2'b00:   f_sel = lane[0];
      2'b01:   f_sel = lane[1];
      2'b10:   f_sel = lane[2];
      2'b11:   f_sel = lane[3];
      default: f_sel = 'x;
    endcase
  end

  assign bus.f = f_sel;

  generate
    if (REG_OUT) begin : g_reg
      logic [W-1:0] f_r;
      logic [1:0]   sel_r;
      logic         vld_r;

      // Capture the selected lane and its select on en; reset wins over en,
      // and the valid flag only marks the cycle right after a capture
      always_ff @(posedge clk) begin
        if (rst) begin
          f_r   <= '0;
          sel_r <= '0;
          vld_r <= 1'b0;
        end else if (bus.en) begin
          f_r   <= f_sel;
          sel_r <= bus.sel;
          vld_r <= 1'b1;
        end else begin
          vld_r <= 1'b0;
        end
      end

      assign bus.f_q   = f_r;
      assign bus.sel_q = sel_r;
      assign bus.vld_q = vld_r;
    end else begin : g_noreg
      assign bus.f_q   = '0;
      assign bus.sel_q = '0;
      assign bus.vld_q = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mux_41_bv.sv
// Directed self-checking bench for mux_41_bv: a W=1 registered instance,
// a W=1 instance without the registered path, and a W=8 registered instance.
module tb_mux_41_bv;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  mux_41_bv_if #(.W(1)) bus1 ();
  mux_41_bv_if #(.W(1)) bus0 ();
  mux_41_bv_if #(.W(8)) bus8 ();

  mux_41_bv #(.W(1), .REG_OUT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux_41_bv #(.W(1), .REG_OUT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux_41_bv #(.W(8), .REG_OUT(1'b1)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the narrow instances on the falling edge, away from capture
  task automatic applyStimulus(input logic [3:0] iv, input logic [1:0] s,
                               input logic e, input logic r);
    @(negedge clk);
    rst      = r;
    bus1.i   = iv;
    bus1.sel = s;
    bus1.en  = e;
    bus0.i   = iv;
    bus0.sel = s;
    bus0.en  = e;
  endtask

  // Drive the wide instance on the falling edge
  task automatic applyWide(input logic [31:0] iv, input logic [1:0] s, input logic e);
    @(negedge clk);
    rst      = 1'b0;
    bus8.i   = iv;
    bus8.sel = s;
    bus8.en  = e;
  endtask

  // Advance past the next rising edge so registered outputs have settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, and on mismatch count and report it
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  pats [4];
  logic [3:0]  expPat [4];
  logic [7:0]  expWide [4];
  logic [3:0]  iv;
  logic        expBit;
  logic [31:0] wideBus;

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    bus1.i = '0; bus1.sel = '0; bus1.en = 1'b0;
    bus0.i = '0; bus0.sel = '0; bus0.en = 1'b0;
    bus8.i = '0; bus8.sel = '0; bus8.en = 1'b0;

    // Hand-computed expected f for sel = 0..3, bit k of expPat = f at sel=k
    pats[0] = 4'b1010; expPat[0] = 4'b1010;
    pats[1] = 4'b0101; expPat[1] = 4'b0101;
    pats[2] = 4'b1111; expPat[2] = 4'b1111;
    pats[3] = 4'b0000; expPat[3] = 4'b0000;
    expWide[0] = 8'hA1; expWide[1] = 8'hB2; expWide[2] = 8'hC3; expWide[3] = 8'hD4;

    $display("[TB] reset for two cycles with en high");
    applyStimulus(4'b1111, 2'b11, 1'b1, 1'b1);
    tick();
    applyStimulus(4'b1111, 2'b11, 1'b1, 1'b1);
    tick();
    checkOutput("rst_f_q",   32'(bus1.f_q),   32'h0);
    checkOutput("rst_sel_q", 32'(bus1.sel_q), 32'h0);
    checkOutput("rst_vld_q", 32'(bus1.vld_q), 32'h0);
    checkOutput("rst_f_q8",  32'(bus8.f_q),   32'h0);

    $display("[TB] combinational sweeps");
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 4; s++) begin
        applyStimulus(pats[p], 2'(s), 1'b0, 1'b0);
        #1;
        checkOutput($sformatf("f_pat%0d_sel%0d", p, s), 32'(bus1.f), 32'(expPat[p][s]));
        checkOutput($sformatf("f0_pat%0d_sel%0d", p, s), 32'(bus0.f), 32'(expPat[p][s]));
      end
    end

    $display("[TB] registered capture then hold");
    applyStimulus(4'b1010, 2'b01, 1'b1, 1'b0);
    tick();
    checkOutput("cap_f_q",   32'(bus1.f_q),   32'h1);
    checkOutput("cap_sel_q", 32'(bus1.sel_q), 32'h1);
    checkOutput("cap_vld_q", 32'(bus1.vld_q), 32'h1);
    checkOutput("noreg_f_q",   32'(bus0.f_q),   32'h0);
    checkOutput("noreg_sel_q", 32'(bus0.sel_q), 32'h0);
    checkOutput("noreg_vld_q", 32'(bus0.vld_q), 32'h0);
    applyStimulus(4'b1010, 2'b10, 1'b0, 1'b0);
    tick();
    checkOutput("hold_f_q",   32'(bus1.f_q),   32'h1);
    checkOutput("hold_sel_q", 32'(bus1.sel_q), 32'h1);
    checkOutput("hold_vld_q", 32'(bus1.vld_q), 32'h0);

    $display("[TB] reset mid-stream with en high");
    applyStimulus(4'b1010, 2'b01, 1'b1, 1'b1);
    tick();
    checkOutput("midrst_f_q",   32'(bus1.f_q),   32'h0);
    checkOutput("midrst_sel_q", 32'(bus1.sel_q), 32'h0);
    checkOutput("midrst_vld_q", 32'(bus1.vld_q), 32'h0);
    applyStimulus(4'b1010, 2'b11, 1'b1, 1'b0);
    tick();
    checkOutput("postrst_f_q",   32'(bus1.f_q),   32'h1);
    checkOutput("postrst_sel_q", 32'(bus1.sel_q), 32'h3);
    checkOutput("postrst_vld_q", 32'(bus1.vld_q), 32'h1);

    $display("[TB] wide lanes, capture every cycle");
    wideBus = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    for (int s = 0; s < 4; s++) begin
      applyWide(wideBus, 2'(s), 1'b1);
      #1;
      checkOutput($sformatf("f8_sel%0d", s), 32'(bus8.f), 32'(expWide[s]));
      tick();
      checkOutput($sformatf("f_q8_sel%0d", s),   32'(bus8.f_q),   32'(expWide[s]));
      checkOutput($sformatf("sel_q8_sel%0d", s), 32'(bus8.sel_q), 32'(s));
      checkOutput($sformatf("vld_q8_sel%0d", s), 32'(bus8.vld_q), 32'h1);
    end

    $display("[TB] exhaustive narrow sweep, capture every cycle");
    for (int v = 0; v < 16; v++) begin
      for (int s = 0; s < 4; s++) begin
        iv     = v[3:0];
        expBit = (v >> s) & 1;
        applyStimulus(iv, 2'(s), 1'b1, 1'b0);
        #1;
        checkOutput($sformatf("ex_f_i%0h_s%0d", v, s), 32'(bus1.f), 32'(expBit));
        tick();
        checkOutput($sformatf("ex_f_q_i%0h_s%0d", v, s),   32'(bus1.f_q),   32'(expBit));
        checkOutput($sformatf("ex_sel_q_i%0h_s%0d", v, s), 32'(bus1.sel_q), 32'(s));
        checkOutput($sformatf("ex_vld_q_i%0h_s%0d", v, s), 32'(bus1.vld_q), 32'h1);
        checkOutput($sformatf("ex_noreg_i%0h_s%0d", v, s),
                    32'({bus0.f_q, bus0.sel_q, bus0.vld_q}), 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
